// File: rtl/calc_issue_sched.sv
// Round-robin issue scheduler: picks one ready ALU-calc reservation-station entry,
// holds the request until the ALU accepts it, then pulses a release for that entry.
module calc_issue_sched #(
  parameter int RS_SIZE = 16,
  parameter int IDX_W   = 4
) (
  input  logic               clk_in,
  input  logic               rstn_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  input  logic [RS_SIZE-1:0] rs_busy,
  input  logic [RS_SIZE-1:0] rs_ready,
  input  logic [RS_SIZE-1:0] rs_is_calc,
  input  logic               alu_ready,
  output logic               alu_valid,
  output logic [IDX_W-1:0]   alu_idx,
  output logic               rel_valid,
  output logic [IDX_W-1:0]   rel_idx,
  output logic [31:0]        issue_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_alu_valid, w_alu_valid_nxt;
  logic [IDX_W-1:0]   r_alu_idx, w_alu_idx_nxt;
  logic               r_rel_valid, w_rel_valid_nxt;
  logic [IDX_W-1:0]   r_rel_idx, w_rel_idx_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [31:0]        r_issue_cnt, w_issue_cnt_nxt;

  logic [RS_SIZE-1:0] w_cand;
  logic [IDX_W-1:0]   w_base, w_probe, w_sel;
  logic               w_found;
  logic               w_hs;

  // Round-robin pick. While holding, the scan starts just past the held entry so a
  // back-to-back selection on the handshake edge already honours the new pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_cand  = rs_busy & rs_ready & rs_is_calc;
    w_base  = r_rr_ptr;
    w_probe = '0;
    w_sel   = '0;
    w_found = 1'b0;
    if (r_state == HOLD) begin
      w_cand[r_alu_idx] = 1'b0;
      w_base            = r_alu_idx + IDX_W'(1);
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      w_probe = w_base + IDX_W'(i);
      if (!w_found && w_cand[w_probe]) begin
        w_found = 1'b1;
        w_sel   = w_probe;
      end
    end
  end

  assign w_hs = (r_state == HOLD) && alu_ready && !flush_in;

  always_comb begin
    w_state_nxt     = r_state;
    w_alu_valid_nxt = r_alu_valid;
    w_alu_idx_nxt   = r_alu_idx;
    w_rel_valid_nxt = 1'b0;
    w_rel_idx_nxt   = r_rel_idx;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_issue_cnt_nxt = r_issue_cnt;
    if (flush_in) begin
      w_state_nxt     = IDLE;
      w_alu_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            w_state_nxt     = HOLD;
            w_alu_valid_nxt = 1'b1;
            w_alu_idx_nxt   = w_sel;
          end
        end
        HOLD: begin
          // An accepted request completes even if the entry drops busy in the same cycle.
          if (w_hs) begin
            w_rel_valid_nxt = 1'b1;
            w_rel_idx_nxt   = r_alu_idx;
            w_rr_ptr_nxt    = r_alu_idx + IDX_W'(1);
            w_issue_cnt_nxt = r_issue_cnt + 32'd1;
            if (w_found) begin
              w_alu_idx_nxt = w_sel;
            end else begin
              w_state_nxt     = IDLE;
              w_alu_valid_nxt = 1'b0;
            end
          end else if (!rs_busy[r_alu_idx]) begin
            w_state_nxt     = IDLE;
            w_alu_valid_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt     = IDLE;
          w_alu_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_state     <= IDLE;
      r_alu_valid <= 1'b0;
      r_alu_idx   <= '0;
      r_rel_valid <= 1'b0;
      r_rel_idx   <= '0;
      r_rr_ptr    <= '0;
      r_issue_cnt <= '0;
    end else if (rdy_in) begin
      r_state     <= w_state_nxt;
      r_alu_valid <= w_alu_valid_nxt;
      r_alu_idx   <= w_alu_idx_nxt;
      r_rel_valid <= w_rel_valid_nxt;
      r_rel_idx   <= w_rel_idx_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
    end else begin
      // NOTE: a frozen cycle must not repeat a release, so only the pulse is cleared.
      r_rel_valid <= 1'b0;
    end
  end

  assign alu_valid = r_alu_valid;
  assign alu_idx   = r_alu_idx;
  assign rel_valid = r_rel_valid;
  assign rel_idx   = r_rel_idx;
  assign issue_cnt = r_issue_cnt;

endmodule
